// File: rtl/sys_clk_rst_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies extlock with a timeout
// and bounded retry, then releases per-domain resets in staggered order.
module sys_clk_rst_seq #(
    parameter int NUM_CH           = 3,
    parameter int PLL_RST_CYC      = 8,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65535,
    parameter int STAGGER_CYC      = 16,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 16
) (
    input  logic              refclk,
    input  logic              reset,
    input  logic              extlock,
    output logic              pll_rst,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              ready,
    output logic              fail,
    output logic [7:0]        lock_lost_cnt
);
    localparam int STB_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]  TMR_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  PLL_LAST   = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0]  TOUT_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  STAG_LAST  = CNT_W'(STAGGER_CYC - 1);
    localparam logic [STB_W-1:0]  STB_ONE    = STB_W'(1);
    localparam logic [STB_W-1:0]  STB_LAST   = STB_W'(LOCK_STABLE_CYC);
    localparam logic [RTY_W-1:0]  RTY_ONE    = RTY_W'(1);
    localparam logic [RTY_W-1:0]  RTY_LAST   = RTY_W'(MAX_RETRY - 1);
    localparam logic [NUM_CH-1:0] CH_ALL     = '1;
    // Releasing is a left shift of zeros into the reset vector, channel 0 first.
    localparam logic [NUM_CH-1:0] CH_FIRST   = CH_ALL << 1;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t            state_q;
    logic              sync1_q;
    logic              lock_s_q;
    logic [CNT_W-1:0]  timer_q;
    logic [STB_W-1:0]  stable_q;
    logic [RTY_W-1:0]  retry_q;
    logic              pll_rst_q;
    logic [NUM_CH-1:0] ch_rst_q;
    logic              ready_q;
    logic              fail_q;
    logic [7:0]        lost_cnt_q;

    logic lock_timeout_d;
    assign lock_timeout_d = (timer_q == TOUT_LAST);

    always_ff @(posedge refclk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            lock_s_q   <= 1'b0;
            state_q    <= S_PLL_RST;
            timer_q    <= '0;
            stable_q   <= '0;
            retry_q    <= '0;
            pll_rst_q  <= 1'b1;
            ch_rst_q   <= CH_ALL;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
            lost_cnt_q <= '0;
        end else begin
            sync1_q  <= extlock;
            lock_s_q <= sync1_q;
            case (state_q)
                S_PLL_RST: begin
                    if (timer_q == PLL_LAST) begin
                        state_q   <= S_WAIT_LOCK;
                        timer_q   <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
                    // Timeout wins over any lock activity in the same cycle.
                    if (lock_timeout_d) begin
                        timer_q   <= '0;
                        stable_q  <= '0;
                        pll_rst_q <= 1'b1;
                        retry_q   <= retry_q + RTY_ONE;
                        if (retry_q == RTY_LAST) begin
                            state_q <= S_FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= S_PLL_RST;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_ONE;
                        if (!lock_s_q) begin
                            state_q  <= S_WAIT_LOCK;
                            stable_q <= '0;
                        end else if (state_q == S_WAIT_LOCK) begin
                            state_q  <= S_STABLE;
                            stable_q <= STB_ONE;
                        end else if (stable_q == STB_LAST) begin
                            state_q  <= S_RELEASE;
                            stable_q <= '0;
                            retry_q  <= '0;
                            timer_q  <= '0;
                            ch_rst_q <= CH_FIRST;
                        end else begin
                            stable_q <= stable_q + STB_ONE;
                        end
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!lock_s_q) begin
                        state_q   <= S_PLL_RST;
                        timer_q   <= '0;
                        retry_q   <= '0;
                        pll_rst_q <= 1'b1;
                        ch_rst_q  <= CH_ALL;
                        ready_q   <= 1'b0;
                        if (lost_cnt_q != 8'hFF) begin
                            lost_cnt_q <= lost_cnt_q + 8'd1;
                        end
                    end else if (state_q == S_RELEASE) begin
                        if (!ch_rst_q[NUM_CH-1]) begin
                            state_q <= S_RUN;
                            ready_q <= 1'b1;
                        end else if (timer_q == STAG_LAST) begin
                            timer_q  <= '0;
                            ch_rst_q <= ch_rst_q << 1;
                        end else begin
                            timer_q <= timer_q + TMR_ONE;
                        end
                    end
                end
                S_FAIL: begin
                    pll_rst_q <= 1'b1;
                    ch_rst_q  <= CH_ALL;
                    ready_q   <= 1'b0;
                    fail_q    <= 1'b1;
                end
                default: begin
                    state_q   <= S_PLL_RST;
                    timer_q   <= '0;
                    pll_rst_q <= 1'b1;
                    ch_rst_q  <= CH_ALL;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst       = pll_rst_q;
    assign ch_rst        = ch_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign lock_lost_cnt = lost_cnt_q;

endmodule

// File: tb/tb_sys_clk_rst_seq.sv
// Directed bench for sys_clk_rst_seq: per-cycle vector table for the sequencing
// scenarios plus hand-written saturation and mid-release reset sequences.
module tb_sys_clk_rst_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       extlock = 1'b0;
    logic       pll_rst;
    logic [2:0] ch_rst;
    logic       ready;
    logic       fail;
    logic [7:0] lock_lost_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    sys_clk_rst_seq #(
        .NUM_CH(3), .PLL_RST_CYC(4), .LOCK_STABLE_CYC(8), .LOCK_TIMEOUT_CYC(20),
        .STAGGER_CYC(2), .MAX_RETRY(2), .CNT_W(16)
    ) dut (
        .refclk(clk), .reset(reset), .extlock(extlock), .pll_rst(pll_rst),
        .ch_rst(ch_rst), .ready(ready), .fail(fail), .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         rst;
        int         tid;
        int         cyc;
        logic       ext;
        logic       pll;
        logic [2:0] ch;
        logic       rdy;
        logic       fl;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, int tid, int c, logic ext, logic pll,
                                logic [2:0] ch, logic rdy, logic fl, logic [7:0] cnt);
        vec_t v;
        v.rst = rst; v.tid = tid; v.cyc = c; v.ext = ext; v.pll = pll;
        v.ch = ch; v.rdy = rdy; v.fl = fl; v.cnt = cnt;
        return v;
    endfunction

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ready === 1'b1) begin
            n_vec++;
            if (ch_rst !== 3'b000 || pll_rst !== 1'b0) begin
                n_bad++;
                $display("FAIL invariant cyc=%0d got ready=1 ch_rst=%b pll_rst=%b required ch_rst=000 pll_rst=0",
                         cyc, ch_rst, pll_rst);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        extlock = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic chk(string nm, logic pll, logic [2:0] ch, logic rdy, logic fl, logic [7:0] cnt);
        n_vec++;
        if (pll_rst !== pll || ch_rst !== ch || ready !== rdy || fail !== fl || lock_lost_cnt !== cnt) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got pll=%b ch=%b rdy=%b fail=%b cnt=%0d required pll=%b ch=%b rdy=%b fail=%b cnt=%0d",
                     nm, cyc, pll_rst, ch_rst, ready, fail, lock_lost_cnt, pll, ch, rdy, fl, cnt);
        end else begin
            $display("vec %s cyc=%0d pll=%b ch=%b rdy=%b fail=%b cnt=%0d ok",
                     nm, cyc, pll_rst, ch_rst, ready, fail, lock_lost_cnt);
        end
    endtask

    task automatic wait_ch0_low();
        int n = 0;
        while (ch_rst[0] !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_ch0_low timeout got ch_rst=%b required ch_rst[0]=0", ch_rst);
        end
    endtask

    task automatic wait_pll_high();
        int n = 0;
        while (pll_rst !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_pll_high timeout got pll_rst=%b required 1", pll_rst);
        end
    endtask

    initial begin
        // T1 nominal bring-up
        vecs.push_back(mk(1, 1,  0, 1, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 1,  3, 1, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 1,  4, 1, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 1, 12, 1, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 1, 13, 1, 0, 3'b110, 0, 0, 0));
        vecs.push_back(mk(0, 1, 14, 1, 0, 3'b110, 0, 0, 0));
        vecs.push_back(mk(0, 1, 15, 1, 0, 3'b100, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16, 1, 0, 3'b100, 0, 0, 0));
        vecs.push_back(mk(0, 1, 17, 1, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 18, 1, 0, 3'b000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 19, 1, 0, 3'b000, 1, 0, 0));
        // T2 one-cycle glitch in STABLE restarts the stable count
        vecs.push_back(mk(1, 2,  0, 1, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 2,  8, 0, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 2,  9, 1, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 2, 19, 1, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 2, 20, 1, 0, 3'b110, 0, 0, 0));
        vecs.push_back(mk(0, 2, 22, 1, 0, 3'b100, 0, 0, 0));
        vecs.push_back(mk(0, 2, 24, 1, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 2, 25, 1, 0, 3'b000, 1, 0, 0));
        // T2b longer glitch pushes the stable window past the timeout
        vecs.push_back(mk(1, 3,  0, 1, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 3,  9, 0, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 3, 13, 1, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 3, 23, 1, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 3, 24, 1, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 3, 27, 1, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 3, 28, 1, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 3, 36, 1, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 3, 37, 1, 0, 3'b110, 0, 0, 0));
        vecs.push_back(mk(0, 3, 41, 1, 0, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 3, 42, 1, 0, 3'b000, 1, 0, 0));
        // T3 no lock: two retries then absorbing FAIL
        vecs.push_back(mk(1, 4,  0, 0, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 4,  3, 0, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 4,  4, 0, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 4, 23, 0, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 4, 24, 0, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 4, 27, 0, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 4, 28, 0, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 4, 47, 0, 0, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 4, 48, 0, 1, 3'b111, 0, 1, 0));
        vecs.push_back(mk(0, 4, 50, 1, 1, 3'b111, 0, 1, 0));
        vecs.push_back(mk(0, 4, 60, 1, 1, 3'b111, 0, 1, 0));
        // T4 lock loss in RUN, 3-cycle drop, then full re-sequence
        vecs.push_back(mk(1, 5,  0, 1, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 5, 18, 1, 0, 3'b000, 1, 0, 0));
        vecs.push_back(mk(0, 5, 20, 0, 0, 3'b000, 1, 0, 0));
        vecs.push_back(mk(0, 5, 22, 0, 0, 3'b000, 1, 0, 0));
        vecs.push_back(mk(0, 5, 23, 1, 1, 3'b111, 0, 0, 1));
        vecs.push_back(mk(0, 5, 26, 1, 1, 3'b111, 0, 0, 1));
        vecs.push_back(mk(0, 5, 27, 1, 0, 3'b111, 0, 0, 1));
        vecs.push_back(mk(0, 5, 35, 1, 0, 3'b111, 0, 0, 1));
        vecs.push_back(mk(0, 5, 36, 1, 0, 3'b110, 0, 0, 1));
        vecs.push_back(mk(0, 5, 41, 1, 0, 3'b000, 1, 0, 1));
        // T5 lock loss during RELEASE
        vecs.push_back(mk(1, 6,  0, 1, 1, 3'b111, 0, 0, 0));
        vecs.push_back(mk(0, 6, 13, 0, 0, 3'b110, 0, 0, 0));
        vecs.push_back(mk(0, 6, 14, 1, 0, 3'b110, 0, 0, 0));
        vecs.push_back(mk(0, 6, 15, 1, 0, 3'b100, 0, 0, 0));
        vecs.push_back(mk(0, 6, 16, 1, 1, 3'b111, 0, 0, 1));
        vecs.push_back(mk(0, 6, 17, 1, 1, 3'b111, 0, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            while (cyc < vecs[i].cyc) tick();
            extlock = vecs[i].ext;
            chk($sformatf("T%0d@%0d", vecs[i].tid, vecs[i].cyc),
                vecs[i].pll, vecs[i].ch, vecs[i].rdy, vecs[i].fl, vecs[i].cnt);
        end

        // T6 saturating loss counter, then a one-cycle reset mid-RELEASE
        do_reset();
        extlock = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            wait_ch0_low();
            extlock = 1'b0;
            tick();
            extlock = 1'b1;
            wait_pll_high();
            if (k == 1 || k == 255 || k == 260)
                chk($sformatf("T6 loss k=%0d", k), 1'b1, 3'b111, 1'b0, 1'b0,
                    (k > 255) ? 8'd255 : 8'(k));
            if (n_bad > 10) break;
        end
        wait_ch0_low();
        chk("T6 pre-reset", 1'b0, 3'b110, 1'b0, 1'b0, 8'd255);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc = 0;
        chk("T6 reset", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0);
        repeat (3) tick();
        chk("T6 post@3", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0);
        tick();
        chk("T6 post@4", 1'b0, 3'b111, 1'b0, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
